// File: rtl/mac_seq_ctrl.sv
// Sequencer for one fused MAC unit: clears the MAC, streams LEN operand pairs and returns the dot product.
// Optional busy-cycle counter output cyc_cnt is built only when MAC_SEQ_CYCCNT_EN is defined.
module mac_seq_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int ADDR_W   = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [BITWIDTH-1:0]     rd_a,
  input  logic [BITWIDTH-1:0]     rd_b,
  output logic                    mac_en,
  output logic [BITWIDTH-1:0]     mac_a,
  output logic [BITWIDTH-1:0]     mac_b,
  input  logic [2*BITWIDTH-1:0]   mac_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*BITWIDTH-1:0]   result,
`ifdef MAC_SEQ_CYCCNT_EN
  output logic [31:0]             cyc_cnt,
`endif
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t                  state_q;
  logic [ADDR_W:0]         len_q;
  logic [ADDR_W:0]         len_d;
  logic                    busy_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic                    dvalid_q;
  logic                    mac_en_q;
  logic                    res_valid_q;
  logic [2*BITWIDTH-1:0]   result_q;
  logic                    last_beat;

  // Oversized commands are clamped so the address counter never wraps.
  assign len_d     = (len > MAX_LEN) ? MAX_LEN : len;
  assign last_beat = ({1'b0, rd_addr_q} == (len_q - 1'b1));

  // Result handshake: a transfer happens on any rising edge where res_valid && res_ready;
  // result and res_valid stay unchanged from CAPT until that edge, and res_ready has no
  // effect while res_valid is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      dvalid_q    <= 1'b0;
      mac_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      dvalid_q <= rd_en_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CLEAR;
            len_q     <= len_d;
            busy_q    <= 1'b1;
            rd_addr_q <= '0;
            mac_en_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          mac_en_q <= 1'b1;
          if (len_q == '0) begin
            state_q <= S_CAPT;
          end else begin
            state_q <= S_RUN;
            rd_en_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (last_beat) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          state_q <= S_CAPT;
        end
        S_CAPT: begin
          // mac_dout already holds the final beat, accumulated at the end of DRAIN.
          result_q    <= mac_dout;
          res_valid_q <= 1'b1;
          mac_en_q    <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign mac_en      = mac_en_q;
  assign mac_a       = dvalid_q ? rd_a : '0;
  assign mac_b       = dvalid_q ? rd_b : '0;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

`ifdef MAC_SEQ_CYCCNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cyc_cnt_q;

  // The value latched on transfer covers CLEAR through CAPT plus any stalled DONE cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      cyc_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if ((state_q == S_DONE) && res_ready) begin
        cyc_cnt_q <= cnt_q;
      end
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: operand memories and MAC modelled here, dot products from a plain-sum model.
module tb_mac_seq_ctrl;
  localparam int BW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     len = '0;
  logic            busy;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [BW-1:0]   rd_a = '0;
  logic [BW-1:0]   rd_b = '0;
  logic            mac_en;
  logic [BW-1:0]   mac_a;
  logic [BW-1:0]   mac_b;
  logic [2*BW-1:0] mac_dout = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [2*BW-1:0] result;
  logic [2:0]      dbg_state;
`ifdef MAC_SEQ_CYCCNT_EN
  logic [31:0]     cyc_cnt;
`endif

  logic [BW-1:0]   mem_a [DEPTH];
  logic [BW-1:0]   mem_b [DEPTH];
  logic [2*BW-1:0] exp_q [$];
  int              n_checks = 0;
  int              n_fail = 0;

  mac_seq_ctrl #(.BITWIDTH(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_dout(mac_dout),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
`ifdef MAC_SEQ_CYCCNT_EN
    .cyc_cnt(cyc_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock, memories, MAC ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    mac_dout <= mac_en ? (mac_dout + 64'(mac_a) * 64'(mac_b)) : '0;
  end

  // ---------------- reference model ----------------
  function automatic logic [2*BW-1:0] dot(input int l);
    int n;
    logic [2*BW-1:0] s;
    n = (l > DEPTH) ? DEPTH : l;
    s = '0;
    for (int i = 0; i < n; i++) s = s + 64'(mem_a[i]) * 64'(mem_b[i]);
    return s;
  endfunction

  function automatic int exp_lat(input int l);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    return (n == 0) ? 2 : n + 3;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cmd(input int l, input int stall, input bit pulse_start,
                        output logic [2*BW-1:0] res, output int lat, output int rd_cnt,
                        output bit addr_ok, output bit hold_ok, output bit idle_ok,
                        output bit timeout);
    res = '0; lat = 0; rd_cnt = 0; addr_ok = 1; hold_ok = 1; idle_ok = 1; timeout = 1;
    @(negedge clk);
    start = 1'b1;
    len   = l[AW:0];
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (rd_en === 1'b1) begin
        if (rd_addr !== AW'(k - 1)) addr_ok = 0;
        rd_cnt++;
      end
      if (res_valid === 1'b1) begin
        lat = k;
        timeout = 0;
        break;
      end
    end
    if (timeout) return;
    res = result;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      start = pulse_start && (s == 1);
      @(posedge clk);
      #1;
      if (res_valid !== 1'b1 || result !== res || busy !== 1'b1 || rd_en !== 1'b0) hold_ok = 0;
    end
    @(negedge clk);
    res_ready = 1'b1;
    start     = pulse_start;
    @(posedge clk);
    #1;
    if (busy !== 1'b0 || res_valid !== 1'b0) idle_ok = 0;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || rd_en !== 1'b0) idle_ok = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, rd_en, rd_addr, mac_en, res_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b rd_en=%b rd_addr=%0d mac_en=%b res_valid=%b expected all 0",
               busy, rd_en, rd_addr, mac_en, res_valid);
    end
    n_checks++;
    if (result !== '0 || mac_a !== '0 || mac_b !== '0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h mac_a=%h mac_b=%h expected 0", result, mac_a, mac_b);
    end
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = BW'(i + 1);
      mem_b[i] = BW'(i + 5);
    end
    exp_q.push_back(dot(4));
    do_cmd(4, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== exp_q.pop_front() || res !== 64'd70) begin
      n_fail++;
      $display("FAIL basic_result: got %0d expected 70 (timeout=%b)", res, to);
    end
    n_checks++;
    if (lat !== 7 || rc !== 4 || !aok) begin
      n_fail++;
      $display("FAIL basic_timing: lat=%0d rd_cnt=%0d addr_ok=%b expected 7/4/1", lat, rc, aok);
    end
    n_checks++;
    if (!iok) begin
      n_fail++;
      $display("FAIL basic_release: busy/res_valid not cleared after transfer");
    end
  endtask

  task automatic test_zero_len();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    do_cmd(0, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== '0 || lat !== 2 || rc !== 0) begin
      n_fail++;
      $display("FAIL zero_len: result=%0d lat=%0d rd_cnt=%0d expected 0/2/0", res, lat, rc);
    end
  endtask

  task automatic test_wrap();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    mem_a[0] = '1; mem_a[1] = '1;
    mem_b[0] = '1; mem_b[1] = '1;
    do_cmd(2, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== 64'hFFFFFFFC_00000002 || res !== dot(2)) begin
      n_fail++;
      $display("FAIL wrap: got %h expected fffffffc00000002", res);
    end
  endtask

  task automatic test_random();
    logic [2*BW-1:0] res;
    int lat, rc, l, st;
    bit aok, hok, iok, to;
    for (int it = 0; it < 8; it++) begin
      fill_random(32);
      l  = $urandom_range(1, 24);
      st = $urandom_range(0, 3);
      exp_q.push_back(dot(l));
      do_cmd(l, st, 0, res, lat, rc, aok, hok, iok, to);
      n_checks++;
      if (to || res !== exp_q.pop_front() || lat !== exp_lat(l) || rc !== l || !aok || !hok || !iok) begin
        n_fail++;
        $display("FAIL random_%0d: len=%0d result=%h lat=%0d rd_cnt=%0d expected %h/%0d/%0d",
                 it, l, res, lat, rc, dot(l), exp_lat(l), l);
      end
    end
  endtask

  task automatic test_clamp();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    fill_random(DEPTH);
    exp_q.push_back(dot(300));
    do_cmd(300, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== exp_q.pop_front() || lat !== 259 || rc !== 256 || !aok) begin
      n_fail++;
      $display("FAIL clamp: result=%h lat=%0d rd_cnt=%0d addr_ok=%b expected %h/259/256/1",
               res, lat, rc, aok, dot(300));
    end
  endtask

  task automatic test_stall();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    fill_random(8);
    do_cmd(5, 5, 1, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== dot(5) || !hok) begin
      n_fail++;
      $display("FAIL stall_hold: result=%h expected %h hold_ok=%b", res, dot(5), hok);
    end
    n_checks++;
    if (!iok) begin
      n_fail++;
      $display("FAIL stall_start_ignored: controller busy after transfer, expected idle");
    end
  endtask

  task automatic test_start_with_ready();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    fill_random(4);
    do_cmd(3, 0, 1, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== dot(3) || !iok) begin
      n_fail++;
      $display("FAIL start_with_ready: result=%h expected %h idle_ok=%b", res, dot(3), iok);
    end
  endtask

  task automatic test_abort();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    fill_random(8);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, rd_en, rd_addr, mac_en, res_valid} !== '0 || result !== '0 || mac_a !== '0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b rd_en=%b rd_addr=%0d mac_en=%b res_valid=%b result=%h state=%0d expected 0",
               busy, rd_en, rd_addr, mac_en, res_valid, result, dbg_state);
    end
    @(negedge clk) rstn = 1'b1;
    mem_a[0] = 32'd3;
    mem_b[0] = 32'd4;
    do_cmd(1, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || res !== 64'd12 || lat !== 4) begin
      n_fail++;
      $display("FAIL abort_recover: result=%0d lat=%0d expected 12/4", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    int lens[3];
    fill_random(16);
    lens[0] = 16; lens[1] = 1; lens[2] = 7;
    for (int i = 0; i < 3; i++) exp_q.push_back(dot(lens[i]));
    for (int i = 0; i < 3; i++) begin
      do_cmd(lens[i], 0, 0, res, lat, rc, aok, hok, iok, to);
      n_checks++;
      if (to || res !== exp_q.pop_front() || lat !== exp_lat(lens[i])) begin
        n_fail++;
        $display("FAIL b2b_%0d: result=%h lat=%0d expected %h/%0d", i, res, lat, dot(lens[i]), exp_lat(lens[i]));
      end
    end
  endtask

`ifdef MAC_SEQ_CYCCNT_EN
  task automatic test_cyc_cnt();
    logic [2*BW-1:0] res;
    int lat, rc;
    bit aok, hok, iok, to;
    fill_random(4);
    do_cmd(4, 0, 0, res, lat, rc, aok, hok, iok, to);
    n_checks++;
    if (to || cyc_cnt !== 32'd7) begin
      n_fail++;
      $display("FAIL cyc_cnt: got %0d expected 7", cyc_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_random();
    test_clamp();
    test_stall();
    test_start_with_ready();
    test_abort();
    test_back_to_back();
`ifdef MAC_SEQ_CYCCNT_EN
    test_cyc_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
